// File: rtl/regfile_mp.sv
// regfile_mp: parametrised multi-port ARM register file.
//   Storage holds indices 0..NREGS-2; index NREGS-1 aliases the PC (r15 input).
//   Three write sources with priority branch_link > A > B, optional write-to-read
//   bypass, per-register busy scoreboard, registered collision/pc_write_err pulses.
// Ports:
//   clk, reset             clock, async active-high reset
//   ra / rd / rd_busy      NRP packed read ports (address, data, busy flag)
//   we_a/wa_a/wd_a         write port A (ALU result)
//   we_b/wa_b/wd_b         write port B (load data / base writeback)
//   branch_link, r15       write r15-4 into LR_IDX; r15 is also the PC read value
//   set_busy, set_idx      mark a register pending
//   busy                   scoreboard vector (bit NREGS-1 always 0)
//   collision              pulse: same-target conflict among enabled writes last cycle
//   pc_write_err           pulse: port A/B targeted PC or out-of-range index last cycle

module regfile_mp_rdport #(
  parameter int WIDTH  = 32,
  parameter int NREGS  = 16,
  parameter int AW     = 4,
  parameter int BYPASS = 1
) (
  input  logic [AW-1:0]                   i_ra,
  input  logic [NREGS-2:0][WIDTH-1:0]     i_mem,
  input  logic [NREGS-2:0]                i_wen,
  input  logic [NREGS-2:0][WIDTH-1:0]     i_wdat,
  input  logic [NREGS-2:0]                i_busy,
  input  logic [WIDTH-1:0]                i_r15,
  output logic [WIDTH-1:0]                o_rd,
  output logic                            o_busy
);
  localparam logic [AW:0] PC_IDX = (AW+1)'(NREGS-1);

  // Compare-select rather than indexing: out-of-range addresses fall through to 0.
  always_comb begin
    o_rd   = '0;
    o_busy = 1'b0;
    if ({1'b0, i_ra} == PC_IDX) begin
      o_rd = i_r15;
    end else begin
      for (int k = 0; k < NREGS-1; k++) begin
        if (i_ra == AW'(k)) begin
          o_rd   = (BYPASS != 0 && i_wen[k]) ? i_wdat[k] : i_mem[k];
          o_busy = i_busy[k];
        end
      end
    end
  end
endmodule

module regfile_mp #(
  parameter int WIDTH  = 32,
  parameter int NREGS  = 16,
  parameter int NRP    = 3,
  parameter int AW     = 4,
  parameter int LR_IDX = 14,
  parameter int BYPASS = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NRP*AW-1:0]    ra,
  output logic [NRP*WIDTH-1:0] rd,
  output logic [NRP-1:0]       rd_busy,
  input  logic                 we_a,
  input  logic [AW-1:0]        wa_a,
  input  logic [WIDTH-1:0]     wd_a,
  input  logic                 we_b,
  input  logic [AW-1:0]        wa_b,
  input  logic [WIDTH-1:0]     wd_b,
  input  logic                 branch_link,
  input  logic [WIDTH-1:0]     r15,
  input  logic                 set_busy,
  input  logic [AW-1:0]        set_idx,
  output logic [NREGS-1:0]     busy,
  output logic                 collision,
  output logic                 pc_write_err
);
  localparam int          NS     = NREGS - 1;
  localparam logic [AW:0] PC_IDX = (AW+1)'(NREGS-1);
  localparam logic [AW:0] LR     = (AW+1)'(LR_IDX);

  logic [NS-1:0][WIDTH-1:0] r_mem;
  logic [NS-1:0]            r_busy;
  logic                     r_coll, r_pcerr;

  logic [WIDTH-1:0]         w_link;
  logic                     w_a_ok, w_b_ok, w_coll, w_pcerr;
  logic [NS-1:0]            w_hit_bl, w_hit_a, w_hit_b, w_wen, w_set;
  logic [NS-1:0][WIDTH-1:0] w_wdat;

  assign w_link = r15 - WIDTH'(4);
  assign w_a_ok = we_a && ({1'b0, wa_a} < PC_IDX);
  assign w_b_ok = we_b && ({1'b0, wa_b} < PC_IDX);

  // Conflicts are judged on raw targets, so two ports aiming at the PC or an
  // invalid index still count as a collision.
  assign w_coll  = (branch_link && we_a && {1'b0, wa_a} == LR) ||
                   (branch_link && we_b && {1'b0, wa_b} == LR) ||
                   (we_a && we_b && wa_a == wa_b);
  assign w_pcerr = (we_a && !w_a_ok) || (we_b && !w_b_ok);

  for (genvar k = 0; k < NS; k++) begin : g_wr
    assign w_hit_bl[k] = branch_link && (k == LR_IDX);
    assign w_hit_a[k]  = w_a_ok && (wa_a == AW'(k));
    assign w_hit_b[k]  = w_b_ok && (wa_b == AW'(k));
    assign w_wen[k]    = w_hit_bl[k] || w_hit_a[k] || w_hit_b[k];
    assign w_wdat[k]   = w_hit_bl[k] ? w_link : (w_hit_a[k] ? wd_a : wd_b);
    assign w_set[k]    = set_busy && (set_idx == AW'(k));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_mem   <= '0;
      r_busy  <= '0;
      r_coll  <= 1'b0;
      r_pcerr <= 1'b0;
    end else begin
      for (int k = 0; k < NS; k++) begin
        if (w_wen[k]) r_mem[k] <= w_wdat[k];
        // A new pending load wins over a write landing the same cycle.
        if (w_set[k])      r_busy[k] <= 1'b1;
        else if (w_wen[k]) r_busy[k] <= 1'b0;
      end
      r_coll  <= w_coll;
      r_pcerr <= w_pcerr;
    end
  end

  for (genvar i = 0; i < NRP; i++) begin : g_rp
    regfile_mp_rdport #(.WIDTH(WIDTH), .NREGS(NREGS), .AW(AW), .BYPASS(BYPASS)) u_rp (
      .i_ra   (ra[i*AW +: AW]),
      .i_mem  (r_mem),
      .i_wen  (w_wen),
      .i_wdat (w_wdat),
      .i_busy (r_busy),
      .i_r15  (r15),
      .o_rd   (rd[i*WIDTH +: WIDTH]),
      .o_busy (rd_busy[i])
    );
  end

  assign busy         = {1'b0, r_busy};
  assign collision    = r_coll;
  assign pc_write_err = r_pcerr;
endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: one bypassing and one non-bypassing instance
// share all inputs; expected values are hand-computed constants.
module tb_regfile_mp;
  logic        clk = 1'b0;
  logic        reset;
  logic [11:0] ra;
  logic        we_a, we_b, branch_link, set_busy;
  logic [3:0]  wa_a, wa_b, set_idx;
  logic [31:0] wd_a, wd_b, r15;

  logic [95:0] rd1, rd0;
  logic [2:0]  rdb1, rdb0;
  logic [15:0] busy1, busy0;
  logic        coll1, coll0, pce1, pce0;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  regfile_mp #(.BYPASS(1)) u_dut (
    .clk(clk), .reset(reset), .ra(ra), .rd(rd1), .rd_busy(rdb1),
    .we_a(we_a), .wa_a(wa_a), .wd_a(wd_a), .we_b(we_b), .wa_b(wa_b), .wd_b(wd_b),
    .branch_link(branch_link), .r15(r15), .set_busy(set_busy), .set_idx(set_idx),
    .busy(busy1), .collision(coll1), .pc_write_err(pce1));

  regfile_mp #(.BYPASS(0)) u_dut0 (
    .clk(clk), .reset(reset), .ra(ra), .rd(rd0), .rd_busy(rdb0),
    .we_a(we_a), .wa_a(wa_a), .wd_a(wd_a), .we_b(we_b), .wa_b(wa_b), .wd_b(wd_b),
    .branch_link(branch_link), .r15(r15), .set_busy(set_busy), .set_idx(set_idx),
    .busy(busy0), .collision(coll0), .pc_write_err(pce0));

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h want 0x%08h", tag, act, exp);
    end
  endtask

  task automatic idle();
    we_a = 0; we_b = 0; branch_link = 0; set_busy = 0;
    wa_a = 0; wa_b = 0; set_idx = 0; wd_a = 0; wd_b = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; r15 = 32'h0; ra = 12'h0;
    idle();
    tick(); tick();
    chk("rst_busy", {16'h0, busy1}, 32'h0);
    chk("rst_coll", {31'h0, coll1}, 32'h0);
    chk("rst_pcerr", {31'h0, pce1}, 32'h0);
    chk("rst_rd0", rd1[31:0], 32'h0);
    reset = 1'b0;

    // dual write, distinct targets
    we_a = 1; wa_a = 4'd1; wd_a = 32'h11; we_b = 1; wa_b = 4'd2; wd_b = 32'h22;
    tick(); idle();
    ra = {4'd0, 4'd2, 4'd1}; #1;
    chk("dual_r1", rd1[31:0], 32'h11);
    chk("dual_r2", rd1[63:32], 32'h22);
    chk("dual_coll", {31'h0, coll1}, 32'h0);

    // dual write, same target: A wins, collision pulses once
    we_a = 1; wa_a = 4'd1; wd_a = 32'h55; we_b = 1; wa_b = 4'd1; wd_b = 32'h99;
    tick(); idle(); #1;
    chk("same_r1", rd1[31:0], 32'h55);
    chk("same_coll", {31'h0, coll1}, 32'h1);
    tick();
    chk("same_coll_drop", {31'h0, coll1}, 32'h0);

    // branch_link beats port A on LR
    branch_link = 1; r15 = 32'h108; we_a = 1; wa_a = 4'd14; wd_a = 32'h5;
    tick(); idle();
    ra = {4'd0, 4'd0, 4'd14}; #1;
    chk("link_r14", rd1[31:0], 32'h104);
    chk("link_coll", {31'h0, coll1}, 32'h1);
    chk("link_nopcerr", {31'h0, pce1}, 32'h0);
    branch_link = 1; r15 = 32'h2;
    tick(); idle(); #1;
    chk("link_wrap", rd1[31:0], 32'hFFFF_FFFE);
    chk("link_alone_coll", {31'h0, coll1}, 32'h0);

    // bypass vs stored, PC alias read
    r15 = 32'h1234;
    ra = {4'd0, 4'd15, 4'd7};
    we_a = 1; wa_a = 4'd7; wd_a = 32'hAA; #1;
    chk("byp_on", rd1[31:0], 32'hAA);
    chk("byp_off_old", rd0[31:0], 32'h0);
    chk("pc_read", rd1[63:32], 32'h1234);
    tick(); idle(); #1;
    chk("byp_off_new", rd0[31:0], 32'hAA);
    // bypass honours priority: A over B
    we_a = 1; wa_a = 4'd7; wd_a = 32'hBB; we_b = 1; wa_b = 4'd7; wd_b = 32'hCC; #1;
    chk("byp_prio", rd1[31:0], 32'hBB);
    tick(); idle();

    // write to PC index ignored, error pulse
    ra = {4'd0, 4'd0, 4'd1};
    we_a = 1; wa_a = 4'd15; wd_a = 32'h77;
    tick(); idle(); #1;
    chk("pcw_err", {31'h0, pce1}, 32'h1);
    chk("pcw_r1", rd1[31:0], 32'h55);
    tick();
    chk("pcw_err_drop", {31'h0, pce1}, 32'h0);

    // scoreboard
    ra = {4'd0, 4'd0, 4'd4};
    set_busy = 1; set_idx = 4'd4;
    tick(); idle(); #1;
    chk("sb_set", {16'h0, busy1}, 32'h10);
    chk("sb_rdbusy", {29'h0, rdb1}, 32'h1);
    we_b = 1; wa_b = 4'd4; wd_b = 32'h44;
    tick(); idle(); #1;
    chk("sb_clr", {16'h0, busy1}, 32'h0);
    chk("sb_clr_data", rd1[31:0], 32'h44);
    set_busy = 1; set_idx = 4'd4; we_a = 1; wa_a = 4'd4; wd_a = 32'h66;
    tick(); idle(); #1;
    chk("sb_setdom_data", rd1[31:0], 32'h66);
    chk("sb_setdom_busy", {16'h0, busy1}, 32'h10);
    chk("sb_setdom_rdb", {29'h0, rdb1}, 32'h1);
    set_busy = 1; set_idx = 4'd15;
    tick(); idle(); #1;
    chk("sb_pc_ignored", {16'h0, busy1}, 32'h10);

    // async reset mid-operation
    we_a = 1; wa_a = 4'd3; wd_a = 32'hDEAD_BEEF;
    tick(); idle();
    set_busy = 1; set_idx = 4'd5;
    tick(); idle();
    ra = {4'd0, 4'd0, 4'd3}; #1;
    chk("mid_r3", rd1[31:0], 32'hDEAD_BEEF);
    chk("mid_busy", {16'h0, busy1}, 32'h30);
    #2 reset = 1'b1; #1;
    chk("arst_r3", rd1[31:0], 32'h0);
    chk("arst_busy", {16'h0, busy1}, 32'h0);
    reset = 1'b0;

    tick();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Parametrised multi-port ARM register file; successor to the current three-port regfile.
- Generalised in data width, register count and read-port count.
- Adds a second write port (base writeback / load result), optional write-to-read bypass, per-register busy scoreboard for multicycle loads, and registered error flags.
- Sits in the datapath between decode and ALU; the controller drives write enables and scoreboard control.

Parameters:
WIDTH, 32, data width of each register
NREGS, 16, architectural register count; index NREGS-1 is the PC alias
NRP, 3, number of read ports
AW, 4, register index width; must satisfy 2**AW >= NREGS
LR_IDX, 14, link register index
BYPASS, 1, 1 = same-cycle write data forwarded to read ports; 0 = reads see stored value only

Ports:
clk  in  1  clock, all state updates on rising edge
reset  in  1  asynchronous, active-high reset
ra  in  NRP*AW  read addresses; port i uses bits [i*AW +: AW]
rd  out  NRP*WIDTH  read data; port i uses bits [i*WIDTH +: WIDTH]
rd_busy  out  NRP  port i addresses a register whose busy bit is set
we_a  in  1  write enable, port A (ALU result)
wa_a  in  AW  write address, port A
wd_a  in  WIDTH  write data, port A
we_b  in  1  write enable, port B (load data / base writeback)
wa_b  in  AW  write address, port B
wd_b  in  WIDTH  write data, port B
branch_link  in  1  write r15 - 4 to LR_IDX
r15  in  WIDTH  PC+8 value supplied by the datapath
set_busy  in  1  mark register set_idx pending
set_idx  in  AW  register to mark busy
busy  out  NREGS  scoreboard vector
collision  out  1  registered pulse: two or more write sources targeted the same register in the previous cycle
pc_write_err  out  1  registered pulse: port A or B targeted NREGS-1, or an index >= NREGS, in the previous cycle

Behaviour:
- Reset (async, active-high): all registers = 0, busy = 0, collision = 0, pc_write_err = 0. Clearing is immediate and independent of clk. A write or set_busy coincident with reset is discarded.
- Storage is NREGS-1 entries (indices 0..NREGS-2). There is no storage for the PC.
- Reads are combinational. rd[i] = r15 when ra[i] == NREGS-1.
- Read of an index >= NREGS returns 0, with rd_busy = 0.
- Bypass (BYPASS=1): if a write to ra[i] is active this cycle, rd[i] returns the winning write value instead of the stored value. Priority applies.
- With BYPASS=0, the new value is visible only after the edge.
- Write sources: branch_link (data r15 - 4, modulo 2**WIDTH), port A, port B.
- Same-target priority: branch_link > A > B. Losing sources are dropped.
- collision = 1 on the following cycle for any same-target conflict among enabled sources. Applies when both ports target an index >= NREGS-1.
- Writes to index NREGS-1 or >= NREGS are ignored, with pc_write_err = 1 on the next cycle. branch_link never raises this flag.
- Each write takes effect on the rising edge; latency 1 cycle into storage.
- Busy scoreboard, per edge, per register k:
  - set_busy && set_idx==k -> busy[k] = 1. Set dominates a simultaneous write to k, so a new load to a just-written register stays pending.
  - Else, a committed write to k (any source) -> busy[k] = 0.
  - Else, hold.
  - set_idx >= NREGS-1 is ignored (no flag).
- rd_busy[i] = busy[ra[i]] from the current registered vector; it is not bypassed.
- collision and pc_write_err are single-cycle pulses unless the condition repeats.

Test Plan:
- Reset mid-operation: load R3 = 0xDEADBEEF, assert busy on R5, then pulse reset between edges -> R3 reads 0 and busy = 0 immediately, before the next edge.
- Dual write: we_a R1 = 0x11, we_b R2 = 0x22 in the same cycle -> after the edge R1 = 0x11, R2 = 0x22, collision = 0. Same cycle with wa_b = R1 -> R1 = 0x11, collision = 1 for exactly one cycle.
- Link priority: branch_link with r15 = 0x108, we_a R14 = 0x5 -> R14 = 0x104, collision = 1. With r15 = 0x2 -> R14 = 0xFFFFFFFE.
- Bypass: BYPASS=1, ra[0] = R7, we_a R7 = 0xAA -> rd[0] = 0xAA in the same cycle. BYPASS=0 -> old value this cycle, 0xAA next cycle. ra[1] = 15 -> rd[1] = r15.
- PC write: we_a with wa_a = 15 -> no register changes, pc_write_err = 1 for one cycle.
- Scoreboard:
  - set_busy R4 -> busy[4] = 1 and rd_busy = 1 when read.
  - we_b R4 -> busy[4] = 0.
  - set_busy R4 with we_a R4 in the same cycle -> data written and busy[4] = 1.
